// File: rtl/mpc_types_pkg.sv
// Shared types for the LSQ credit scheduler: reload FSM states, the channel id type
// and the starvation threshold.
package mpc_types;

    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } lsq_crdt_fsm_e;

    // Wide enough for the largest supported channel count (8).
    typedef logic [2:0] crdt_ch_id_t;

    localparam int CRDT_STALL_LIMIT = 1023;

endpackage

// File: rtl/crdt_age_picker.sv
// Rotate-priority picker: returns the first requester at or after i_ref_ptr
// (modulo N) as a one-hot grant. Purely combinational.
module crdt_age_picker #(
    parameter  int N     = 16,
    localparam int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ref_ptr,
    output logic [N-1:0]     o_gnt,
    output logic             o_valid
);

    always_comb begin
        logic [IDX_W-1:0] v_pos;
        o_gnt   = '0;
        o_valid = 1'b0;
        v_pos   = '0;
        for (int k = 0; k < N; k++) begin
            // Index arithmetic wraps naturally because N is a power of two.
            v_pos = IDX_W'(i_ref_ptr + IDX_W'(k));
            if (!o_valid && i_req[v_pos]) begin
                o_gnt[v_pos] = 1'b1;
                o_valid      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lsq_credit_scheduler.sv
// Per-channel credit tracking and oldest-first grant of pending LSQ entries, with
// drain-then-reload of all counters. Optional starvation check: LSQ_CRDT_STARVE_CHK_EN.
module lsq_credit_scheduler
    import mpc_types::*;
#(
    parameter  int CH_NUM   = 3,
    parameter  int LSQ_SIZE = 16,
    parameter  int CRDT_MAX = 8,
    parameter  int RTN_MAX  = 2,
    localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1,
    localparam int IDX_W    = $clog2(LSQ_SIZE),
    localparam int CRDT_W   = $clog2(CRDT_MAX + 1),
    localparam int RTN_W    = $clog2(RTN_MAX + 1)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          alloc_valid,
    input  logic [IDX_W-1:0]              alloc_idx,
    input  logic [CH_W-1:0]               alloc_ch,
    input  logic                          alloc_need_crdt,
    input  logic [LSQ_SIZE-1:0]           dealloc_vec,
    input  logic [IDX_W-1:0]              lsq_btm_ptr,
    input  logic [CH_NUM*RTN_W-1:0]       crdt_rtn,
    input  logic                          reload_valid,
    input  logic [CRDT_W-1:0]             reload_crdt,
    output logic [LSQ_SIZE-1:0]           entry_grant,
    output logic [CH_NUM*CRDT_W-1:0]      crdt_avail,
    output logic [CH_NUM*(IDX_W+1)-1:0]   pend_cnt,
    output logic                          reload_busy,
    output lsq_crdt_fsm_e                 dbg_state
`ifdef LSQ_CRDT_STARVE_CHK_EN
    ,
    output logic [CH_NUM-1:0]             starve_flag
`endif
);

    localparam int EFF_W = ((CRDT_W > RTN_W) ? CRDT_W : RTN_W) + 1;
    localparam int CNT_W = IDX_W + 1;

    lsq_crdt_fsm_e       r_state, w_state_nxt;
    logic [LSQ_SIZE-1:0] r_pending, w_pending_nxt;
    logic [LSQ_SIZE-1:0] r_entry_grant, w_grant_nxt;
    logic [CH_W-1:0]     r_entry_ch [LSQ_SIZE];
    logic [CRDT_W-1:0]   r_crdt [CH_NUM];
    logic [CRDT_W-1:0]   w_crdt_nxt [CH_NUM];
    logic [CNT_W-1:0]    r_pend_cnt [CH_NUM];
    logic [CNT_W-1:0]    w_pend_cnt_nxt [CH_NUM];
    logic [LSQ_SIZE-1:0] w_pick [CH_NUM];
    logic [CH_NUM-1:0]   w_pick_vld, w_alloc_cand, w_gnt_old, w_gnt_new, w_gnt, w_ovf;
    logic                w_grant_en, w_load;
    logic [CRDT_W-1:0]   w_reload_clip;

    // Request vectors exclude entries retired or overwritten this cycle.
    for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
        logic [LSQ_SIZE-1:0] w_req;
        always_comb begin
            for (int i = 0; i < LSQ_SIZE; i++) begin
                w_req[i] = r_pending[i] && !dealloc_vec[i]
                         && !(alloc_valid && (alloc_idx == IDX_W'(i)))
                         && (crdt_ch_id_t'(r_entry_ch[i]) == crdt_ch_id_t'(c));
            end
        end
        crdt_age_picker #(.N(LSQ_SIZE)) u_picker (
            .i_req     (w_req),
            .i_ref_ptr (lsq_btm_ptr),
            .o_gnt     (w_pick[c]),
            .o_valid   (w_pick_vld[c])
        );
    end

    assign w_grant_en    = (r_state == RUN) && !reload_valid;
    assign w_reload_clip = (reload_crdt > CRDT_W'(CRDT_MAX)) ? CRDT_W'(CRDT_MAX) : reload_crdt;

    always_comb begin
        logic v_pend_idle;
        w_state_nxt = r_state;
        w_load      = 1'b0;
        v_pend_idle = 1'b1;
        for (int c = 0; c < CH_NUM; c++) begin
            if (r_pend_cnt[c] != '0) v_pend_idle = 1'b0;
        end
        case (r_state)
            RUN: begin
                if (reload_valid) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (v_pend_idle && !(alloc_valid && alloc_need_crdt)) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    always_comb begin
        logic [EFF_W-1:0] v_eff, v_sum;
        w_pending_nxt = r_pending & ~dealloc_vec;
        w_grant_nxt   = r_entry_grant & ~dealloc_vec;
        v_eff = '0;
        v_sum = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            v_eff = EFF_W'(r_crdt[c]) + EFF_W'(crdt_rtn[c*RTN_W +: RTN_W]);
            w_alloc_cand[c] = alloc_valid && alloc_need_crdt
                            && (crdt_ch_id_t'(alloc_ch) == crdt_ch_id_t'(c));
            // Registered pending entries are always older than the incoming one.
            w_gnt_old[c] = w_grant_en && (v_eff != '0) && w_pick_vld[c];
            w_gnt_new[c] = w_grant_en && (v_eff != '0) && !w_pick_vld[c] && w_alloc_cand[c];
            w_gnt[c]     = w_gnt_old[c] | w_gnt_new[c];
            if (w_gnt_old[c]) begin
                w_pending_nxt = w_pending_nxt & ~w_pick[c];
                w_grant_nxt   = w_grant_nxt | w_pick[c];
            end
            v_sum    = v_eff - EFF_W'(w_gnt[c]);
            w_ovf[c] = !w_load && (v_sum > EFF_W'(CRDT_MAX));
            if (w_load)        w_crdt_nxt[c] = w_reload_clip;
            else if (w_ovf[c]) w_crdt_nxt[c] = CRDT_W'(CRDT_MAX);
            else               w_crdt_nxt[c] = v_sum[CRDT_W-1:0];
        end
        // Alloc is applied last so it wins over a same-index dealloc.
        if (alloc_valid) begin
            w_pending_nxt[alloc_idx] = alloc_need_crdt && !(|w_gnt_new);
            w_grant_nxt[alloc_idx]   = !alloc_need_crdt || (|w_gnt_new);
        end
    end

    always_comb begin
        logic [CH_W-1:0] v_ch;
        v_ch = '0;
        for (int c = 0; c < CH_NUM; c++) w_pend_cnt_nxt[c] = '0;
        for (int i = 0; i < LSQ_SIZE; i++) begin
            v_ch = (alloc_valid && (alloc_idx == IDX_W'(i))) ? alloc_ch : r_entry_ch[i];
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_pending_nxt[i] && (crdt_ch_id_t'(v_ch) == crdt_ch_id_t'(c)))
                    w_pend_cnt_nxt[c] = w_pend_cnt_nxt[c] + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RUN;
            r_pending     <= '0;
            r_entry_grant <= '0;
            for (int i = 0; i < LSQ_SIZE; i++) r_entry_ch[i] <= '0;
            for (int c = 0; c < CH_NUM; c++) begin
                r_crdt[c]     <= CRDT_W'(CRDT_MAX);
                r_pend_cnt[c] <= '0;
            end
        end else begin
            r_state       <= w_state_nxt;
            r_pending     <= w_pending_nxt;
            r_entry_grant <= w_grant_nxt;
            if (alloc_valid) r_entry_ch[alloc_idx] <= alloc_ch;
            for (int c = 0; c < CH_NUM; c++) begin
                r_crdt[c]     <= w_crdt_nxt[c];
                r_pend_cnt[c] <= w_pend_cnt_nxt[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            crdt_avail[c*CRDT_W +: CRDT_W] = r_crdt[c];
            pend_cnt[c*CNT_W +: CNT_W]     = r_pend_cnt[c];
        end
    end

    assign entry_grant = r_entry_grant;
    assign reload_busy = (r_state == DRAIN);
    assign dbg_state   = r_state;

    // Returns beyond CRDT_MAX mean the xbar returned credit that was never taken.
    a_crdt_no_ovf: assert property (@(posedge clk) disable iff (!rst_n) w_ovf == '0);

`ifdef LSQ_CRDT_STARVE_CHK_EN
    logic [15:0]       r_stall_cnt [CH_NUM];
    logic [CH_NUM-1:0] r_starve;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_starve <= '0;
            for (int c = 0; c < CH_NUM; c++) r_stall_cnt[c] <= '0;
        end else begin
            for (int c = 0; c < CH_NUM; c++) begin
                if (w_gnt[c]) begin
                    r_stall_cnt[c] <= '0;
                    r_starve[c]    <= 1'b0;
                end else if (r_pend_cnt[c] != '0) begin
                    if (r_stall_cnt[c] != 16'hFFFF) r_stall_cnt[c] <= r_stall_cnt[c] + 16'd1;
                    if (r_stall_cnt[c] >= 16'(CRDT_STALL_LIMIT - 1)) r_starve[c] <= 1'b1;
                end
            end
        end
    end

    assign starve_flag = r_starve;

    a_no_starve: assert property (@(posedge clk) disable iff (!rst_n) starve_flag == '0);
`endif

endmodule

// File: tb/tb_lsq_credit_scheduler.sv
// Directed and randomized bench for lsq_credit_scheduler; expected outputs are queued
// per cycle and compared one cycle later.
module tb_lsq_credit_scheduler;

    localparam int CH_NUM   = 3;
    localparam int LSQ_SIZE = 16;
    localparam int CRDT_MAX = 8;
    localparam int RTN_MAX  = 2;
    localparam int CH_W     = 2;
    localparam int IDX_W    = 4;
    localparam int CRDT_W   = 4;
    localparam int RTN_W    = 2;
    localparam int CNT_W    = IDX_W + 1;
    localparam int EXP_W    = LSQ_SIZE + CH_NUM*CRDT_W + CH_NUM*CNT_W + 1;

    logic                        clk;
    logic                        rst_n;
    logic                        alloc_valid;
    logic [IDX_W-1:0]            alloc_idx;
    logic [CH_W-1:0]             alloc_ch;
    logic                        alloc_need_crdt;
    logic [LSQ_SIZE-1:0]         dealloc_vec;
    logic [IDX_W-1:0]            lsq_btm_ptr;
    logic [CH_NUM*RTN_W-1:0]     crdt_rtn;
    logic                        reload_valid;
    logic [CRDT_W-1:0]           reload_crdt;
    logic [LSQ_SIZE-1:0]         entry_grant;
    logic [CH_NUM*CRDT_W-1:0]    crdt_avail;
    logic [CH_NUM*CNT_W-1:0]     pend_cnt;
    logic                        reload_busy;
    mpc_types::lsq_crdt_fsm_e    dbg_state;
`ifdef LSQ_CRDT_STARVE_CHK_EN
    logic [CH_NUM-1:0]           starve_flag;
`endif

    lsq_credit_scheduler #(
        .CH_NUM   (CH_NUM),
        .LSQ_SIZE (LSQ_SIZE),
        .CRDT_MAX (CRDT_MAX),
        .RTN_MAX  (RTN_MAX)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid     (alloc_valid),
        .alloc_idx       (alloc_idx),
        .alloc_ch        (alloc_ch),
        .alloc_need_crdt (alloc_need_crdt),
        .dealloc_vec     (dealloc_vec),
        .lsq_btm_ptr     (lsq_btm_ptr),
        .crdt_rtn        (crdt_rtn),
        .reload_valid    (reload_valid),
        .reload_crdt     (reload_crdt),
        .entry_grant     (entry_grant),
        .crdt_avail      (crdt_avail),
        .pend_cnt        (pend_cnt),
        .reload_busy     (reload_busy),
        .dbg_state       (dbg_state)
`ifdef LSQ_CRDT_STARVE_CHK_EN
        ,
        .starve_flag     (starve_flag)
`endif
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected-state model and scoreboard
    int                  n_checks;
    int                  n_errors;
    logic [LSQ_SIZE-1:0] e_grant;
    int                  e_crdt [CH_NUM];
    int                  e_pend [CH_NUM];
    logic                e_busy;
    logic [EXP_W-1:0]    exp_q [$];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic push_exp();
        logic [CH_NUM*CRDT_W-1:0] c;
        logic [CH_NUM*CNT_W-1:0]  p;
        for (int i = 0; i < CH_NUM; i++) begin
            c[i*CRDT_W +: CRDT_W] = CRDT_W'(e_crdt[i]);
            p[i*CNT_W +: CNT_W]   = CNT_W'(e_pend[i]);
        end
        exp_q.push_back({e_grant, c, p, e_busy});
    endtask

    task automatic compare_out();
        logic [EXP_W-1:0] e;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard: got 0 queued entries, expected 1");
            return;
        end
        e = exp_q.pop_front();
        check_eq("entry_grant", 64'(entry_grant), 64'(e[EXP_W-1 -: LSQ_SIZE]));
        check_eq("crdt_avail", 64'(crdt_avail), 64'(e[1 + CH_NUM*CNT_W +: CH_NUM*CRDT_W]));
        check_eq("pend_cnt", 64'(pend_cnt), 64'(e[1 +: CH_NUM*CNT_W]));
        check_eq("reload_busy", 64'(reload_busy), 64'(e[0]));
        check_eq("fsm_state", 64'(dbg_state), e[0] ? 64'(mpc_types::DRAIN) : 64'(mpc_types::RUN));
    endtask

    // Driver tasks
    task automatic clear_in();
        alloc_valid     = 1'b0;
        alloc_idx       = '0;
        alloc_ch        = '0;
        alloc_need_crdt = 1'b0;
        dealloc_vec     = '0;
        crdt_rtn        = '0;
        reload_valid    = 1'b0;
    endtask

    task automatic do_alloc(input int idx, input int ch, input bit need);
        alloc_valid     = 1'b1;
        alloc_idx       = IDX_W'(idx);
        alloc_ch        = CH_W'(ch);
        alloc_need_crdt = need;
    endtask

    task automatic do_rtn(input int ch, input int n);
        crdt_rtn[ch*RTN_W +: RTN_W] = RTN_W'(n);
    endtask

    task automatic set_all_crdt(input int v);
        for (int i = 0; i < CH_NUM; i++) e_crdt[i] = v;
    endtask

    task automatic tick();
        push_exp();
        @(posedge clk);
        #1;
        compare_out();
        clear_in();
    endtask

    // Stimulus
    initial begin
        int idx;
        int ch;
        logic [LSQ_SIZE-1:0] dv;
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        clear_in();
        reload_crdt = '0;
        lsq_btm_ptr = '0;
        e_grant     = '0;
        e_busy      = 1'b0;
        set_all_crdt(CRDT_MAX);
        for (int i = 0; i < CH_NUM; i++) e_pend[i] = 0;

        repeat (2) @(posedge clk);
        #1;
        push_exp();
        compare_out();
        rst_n = 1'b1;
        tick();

        // Bring every channel down to 2 credits
        reload_valid = 1'b1; reload_crdt = 4'd2; e_busy = 1'b1; tick();
        e_busy = 1'b0; set_all_crdt(2); tick();

        // Three loads on ch0: two granted, third waits for a return
        do_alloc(0, 0, 1); e_grant[0] = 1'b1; e_crdt[0] = 1; tick();
        do_alloc(1, 0, 1); e_grant[1] = 1'b1; e_crdt[0] = 0; tick();
        do_alloc(2, 0, 1); e_pend[0] = 1; tick();
        do_rtn(0, 1); e_grant[2] = 1'b1; e_pend[0] = 0; tick();

        // Retire them, then reload to 1 credit
        dealloc_vec = 16'h0007; e_grant = '0; tick();
        reload_valid = 1'b1; reload_crdt = 4'd1; e_busy = 1'b1; tick();
        e_busy = 1'b0; set_all_crdt(1); tick();

        // Wrap-around age: btm=14, pending idx1 and idx15 on ch1
        do_alloc(8, 1, 1); e_grant[8] = 1'b1; e_crdt[1] = 0; tick();
        lsq_btm_ptr = 4'd14;
        do_alloc(1, 1, 1); e_pend[1] = 1; tick();
        do_alloc(15, 1, 1); e_pend[1] = 2; tick();
        do_rtn(1, 1); e_grant[15] = 1'b1; e_pend[1] = 1; tick();
        tick();
        do_rtn(1, 1); e_grant[1] = 1'b1; e_pend[1] = 0; tick();

        // Store on a channel with no credit
        do_alloc(9, 2, 1); e_grant[9] = 1'b1; e_crdt[2] = 0; tick();
        do_alloc(5, 2, 0); e_grant[5] = 1'b1; tick();

        // Dealloc and realloc of the same index in one cycle
        do_alloc(3, 0, 1); e_grant[3] = 1'b1; e_crdt[0] = 0; tick();
        do_rtn(0, 2); e_crdt[0] = 2; tick();
        dealloc_vec[3] = 1'b1; do_alloc(3, 0, 1); e_crdt[0] = 1; tick();

        // Reload while ch1 holds two pending entries
        do_alloc(10, 1, 1); e_pend[1] = 1; tick();
        do_alloc(11, 1, 1); e_pend[1] = 2; tick();
        reload_valid = 1'b1; reload_crdt = 4'd4; e_busy = 1'b1; tick();
        do_rtn(1, 1); e_crdt[1] = 1; do_alloc(12, 0, 0); e_grant[12] = 1'b1; tick();
        do_alloc(13, 2, 1); e_pend[2] = 1; tick();
        dealloc_vec = 16'h2C00; e_pend[1] = 0; e_pend[2] = 0; tick();
        do_rtn(0, 1); e_busy = 1'b0; set_all_crdt(4); tick();

        // Reload value above CRDT_MAX is clipped
        reload_valid = 1'b1; reload_crdt = 4'd15; e_busy = 1'b1; tick();
        e_busy = 1'b0; set_all_crdt(CRDT_MAX); tick();

        // Random credit-free allocs mixed with random retirements
        for (int k = 0; k < 20; k++) begin
            idx = $urandom_range(0, LSQ_SIZE - 1);
            ch  = $urandom_range(0, CH_NUM - 1);
            dv  = LSQ_SIZE'($urandom_range(0, 65535)) & LSQ_SIZE'($urandom_range(0, 65535));
            lsq_btm_ptr = IDX_W'($urandom_range(0, LSQ_SIZE - 1));
            dealloc_vec = dv;
            do_alloc(idx, ch, 0);
            e_grant = e_grant & ~dv;
            e_grant[idx] = 1'b1;
            tick();
        end

        // Reset mid-operation
        rst_n = 1'b0;
        #2;
        e_grant = '0; e_busy = 1'b0; set_all_crdt(CRDT_MAX);
        for (int i = 0; i < CH_NUM; i++) e_pend[i] = 0;
        push_exp();
        compare_out();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        do_alloc(4, 0, 1); e_grant[4] = 1'b1; e_crdt[0] = CRDT_MAX - 1; tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/lsq_credit_scheduler.md
Name: lsq_credit_scheduler

Overview:
- Parametrised successor to the ISU per-channel credit manager, between HTU dispatch, LSQ and xbar credit-return path.
- Tracks downstream credits for CH_NUM channels; grants at most one pending LSQ entry per channel per cycle, oldest first relative to the LSQ bottom pointer.
- Adds dealloc/flush, runtime credit reload, multi-credit return per cycle and per-channel occupancy outputs.

Parameters:
- CH_NUM, 3, number of downstream channels (1..8).
- LSQ_SIZE, 16, LSQ entries (power of 2).
- CRDT_MAX, 8, max credits per channel; reset value of every counter.
- RTN_MAX, 2, max credits returned per channel per cycle.
- CH_W, $clog2(CH_NUM) (min 1), channel id width (derived).
- IDX_W, $clog2(LSQ_SIZE), LSQ index width (derived).
- CRDT_W, $clog2(CRDT_MAX+1), credit counter width (derived).
- RTN_W, $clog2(RTN_MAX+1), return count width (derived).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- alloc_valid  in  1  new LSQ entry written this cycle.
- alloc_idx  in  IDX_W  LSQ index written.
- alloc_ch  in  CH_W  binary channel id of new entry.
- alloc_need_crdt  in  1  1 = load/RAE (needs credit); 0 = store/WAE (no credit).
- dealloc_vec  in  LSQ_SIZE  entries retired/flushed this cycle.
- lsq_btm_ptr  in  IDX_W  oldest LSQ entry, age reference.
- crdt_rtn  in  CH_NUM*RTN_W  per-channel credits returned this cycle.
- reload_valid  in  1  reload all counters.
- reload_crdt  in  CRDT_W  reload value, clipped to CRDT_MAX.
- entry_grant  out  LSQ_SIZE  registered; entry may execute.
- crdt_avail  out  CH_NUM*CRDT_W  registered credit count per channel.
- pend_cnt  out  CH_NUM*(IDX_W+1)  registered pending entries per channel.
- reload_busy  out  1  reload waiting for drain.

Behaviour:
- Reset: entry_grant=0, pending vector=0, channel table=0, crdt_avail=CRDT_MAX for all channels, pend_cnt=0, reload_busy=0, FSM=RUN.
- Internal state: pending[LSQ_SIZE], entry_ch[LSQ_SIZE]. pend_cnt is the registered popcount of pending per channel, never a separate counter.
- Per channel c, each cycle: avail_eff = crdt_avail[c] + crdt_rtn[c] (same-cycle return usable).
- Candidates = registered pending entries of c, plus the new entry if alloc_need_crdt and alloc_ch==c. Registered pending entries are older than the new entry.
- If avail_eff>0 and any candidate exists, grant the oldest: minimum (idx - lsq_btm_ptr) mod LSQ_SIZE. Set entry_grant next cycle, clear pending. Max one grant per channel per cycle.
- Ungranted credit-needing alloc sets pending[alloc_idx]; alloc with alloc_need_crdt=0 sets entry_grant[alloc_idx] next cycle.
- crdt_avail[c]' = crdt_avail[c] + crdt_rtn[c] - grant_c. Result >CRDT_MAX is a protocol error: assertion fires, RTL saturates at CRDT_MAX. Underflow is impossible by construction.
- Dealloc clears entry_grant and pending. Credit is not returned; the xbar returns it.
- Same index in alloc and dealloc in one cycle: alloc wins.
- Granted index also in dealloc_vec in the same cycle: grant suppressed, credit not consumed.
- Latency: alloc to entry_grant is 1 cycle when credit is available. Return to grant of a pending entry is 1 cycle.
- Reload FSM:
  - RUN: reload_valid goes to DRAIN, and grants stop.
  - DRAIN (reload_busy=1): when every pend_cnt=0 and no alloc_valid with alloc_need_crdt=1 this cycle, load all counters with the clipped reload_crdt and return to RUN.
  - crdt_rtn is dropped in the load cycle.
  - Allocs during DRAIN still enter pending; credit-free allocs are still granted.
- Reset mid-operation clears all state; no grants survive.

Optional Feature:
- Macro LSQ_CRDT_STARVE_CHK_EN.
- Defined: per-channel 16-bit saturating stall counter increments each cycle with pend_cnt[c]>0 and no grant, clears on grant. Adds output starve_flag (CH_NUM bits, registered), set when the counter reaches 1023 and cleared on grant. Adds assertion starve_flag==0.
- Undefined: no counters, no starve_flag port, identical grant behaviour.

Decomposition:
- mpc_types package gets: lsq_crdt_fsm_e {RUN, DRAIN}, typedef crdt_ch_id_t, and localparam CRDT_STALL_LIMIT=1023.
- Sub-module crdt_age_picker, instantiated once per channel.
  - Inputs: request vector, reference pointer.
  - Outputs: one-hot grant plus valid. Purely combinational, rotate-priority.

Test Plan:
- Reset, CRDT_MAX=2, 3 loads ch0 at idx 0,1,2 on consecutive cycles -> grants idx0, idx1; idx2 pending; crdt_avail[0]=0, pend_cnt[0]=1.
- Then crdt_rtn[0]=1 -> idx2 granted next cycle; crdt_avail[0]=0, pend_cnt[0]=0.
- Wrap: lsq_btm_ptr=14, pending ch1 at idx 15 and 1, crdt_rtn[1]=1 -> idx15 granted first; with CRDT_MAX=1 a further return is needed before idx1 is granted.
- Store alloc ch2 idx5 with zero credits -> entry_grant[5]=1 next cycle; crdt_avail[2] unchanged.
- Same cycle: dealloc idx3 (granted) and alloc idx3 load ch0 with credit -> entry_grant[3]=1, crdt_avail[0] decremented by 1.
- reload_valid with reload_crdt=4 while pend_cnt[1]=2 -> reload_busy=1, no grants; flush both via dealloc_vec -> next cycle all crdt_avail=4, reload_busy=0.
